// File: rtl/mux_out_skid_reg.sv
// mux_out_skid_reg
// Registered pipeline stage that sits directly after the 32-bit 4x1 operand
// mux. It captures the mux output together with the select code that
// produced it. It then hands both to the next datapath stage over a
// valid/ready handshake. A one-entry skid buffer lets in_ready come straight
// from a flop while still sustaining one beat per cycle under back-pressure.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   upstream beat valid
//   in_data    mux output Y
//   in_sel     mux select S that produced in_data
//   in_ready   stage can accept a beat this cycle (registered)
//   out_valid  out_data/out_sel hold a valid beat
//   out_data   registered data to the next stage
//   out_sel    registered select tag
//   out_ready  downstream accepts the beat this cycle
//   xfer_cnt   count of accepted output beats, wraps 255 -> 0
module mux_out_skid_reg #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready,
  output logic [7:0]       xfer_cnt
);

  // State encoding is exactly {main valid, skid valid}, so no separate
  // state register is kept; the valid flags are the state.
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    ILLEGAL = 2'b01,
    ONE     = 2'b10,
    FULL    = 2'b11
  } state_t;

  logic [WIDTH-1:0] m_data, m_data_nxt;
  logic [SEL_W-1:0] m_sel, m_sel_nxt;
  logic             m_valid, m_valid_nxt;
  logic [WIDTH-1:0] k_data, k_data_nxt;
  logic [SEL_W-1:0] k_sel, k_sel_nxt;
  logic             k_valid, k_valid_nxt;
  logic             in_ready_q, in_ready_nxt;
  logic [7:0]       cnt_q, cnt_nxt;

  logic   in_xfer;
  logic   out_xfer;
  state_t state;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = m_valid & out_ready;
  assign state    = state_t'({m_valid, k_valid});

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_sel   = m_sel;
  assign xfer_cnt  = cnt_q;

  always_comb begin
    m_data_nxt  = m_data;
    m_sel_nxt   = m_sel;
    m_valid_nxt = m_valid;
    k_data_nxt  = k_data;
    k_sel_nxt   = k_sel;
    k_valid_nxt = k_valid;
    cnt_nxt     = cnt_q;

    case (state)
      // The unreachable (0,1) state falls back to EMPTY and drops the skid.
      EMPTY, ILLEGAL: begin
        k_valid_nxt = 1'b0;
        if (in_xfer) begin
          m_data_nxt  = in_data;
          m_sel_nxt   = in_sel;
          m_valid_nxt = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          m_data_nxt = in_data;
          m_sel_nxt  = in_sel;
        end else if (out_xfer) begin
          m_valid_nxt = 1'b0;
        end else if (in_xfer) begin
          // Main is stalled, so the new beat parks in the skid slot.
          k_data_nxt  = in_data;
          k_sel_nxt   = in_sel;
          k_valid_nxt = 1'b1;
        end
      end
      FULL: begin
        // The skid beat is older than anything upstream, so it moves up first.
        if (out_xfer) begin
          m_data_nxt  = k_data;
          m_sel_nxt   = k_sel;
          k_valid_nxt = 1'b0;
        end
      end
      default: begin
      end
    endcase

    if (out_xfer) begin
      cnt_nxt = cnt_q + 8'd1;
    end

    // The stage is ready whenever the skid slot will be free next cycle.
    in_ready_nxt = ~k_valid_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_data     <= '0;
      m_sel      <= '0;
      m_valid    <= 1'b0;
      k_data     <= '0;
      k_sel      <= '0;
      k_valid    <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= 8'd0;
    end else begin
      m_data     <= m_data_nxt;
      m_sel      <= m_sel_nxt;
      m_valid    <= m_valid_nxt;
      k_data     <= k_data_nxt;
      k_sel      <= k_sel_nxt;
      k_valid    <= k_valid_nxt;
      in_ready_q <= in_ready_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

endmodule
